aes_frame_loader: RTL and testbench
===================================

# aes_frame_loader

Byte-serial frame loader for the AES datapath: accepts a stream of bytes over a valid/ready handshake, assembles a 128-bit plaintext and a 128/192/256-bit cipher key, and presents them atomically to the KeyExpansion/Cipher/Decipher chain with a one-cycle load strobe. It is the producing end of the text/key interface that the AES top consumes. It replaces the hard-wired text and key constants, which remain as reset values.

## Interface
- TIMEOUT, 1000: maximum idle cycles between bytes inside a frame; 0 disables the timeout.
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- byte_in  input  8  data byte.
- byte_valid  input  1  byte_in is valid this cycle.
- byte_ready  output  1  loader can accept a byte this cycle.
- mode  input  2  key size: 0 = 128, 1 = 192, 2 = 256, 3 = treated as 0. Sampled only on the first byte of a frame.
- abort  input  1  synchronous frame cancel.
- text_out  output  128  plaintext, bit 0 = MSB, `[0:127]` ordering.
- key_out  output  256  key, `[0:255]` ordering, left-justified; unused tail bits are zero.
- key_mode  output  2  latched mode of the last loaded frame (0/1/2).
- load  output  1  one-cycle pulse; text_out/key_out/key_mode just updated.
- busy  output  1  frame in progress (state TEXT or KEY).
- frame_err  output  1  one-cycle pulse on timeout.

## Operation
- Transfer occurs on a rising clk edge when byte_valid && byte_ready.
- Frame layout:
  - 16 text bytes, then KB key bytes, where KB = 16/24/32 for mode 0/1/2.
  - Byte i of the text goes to shadow_text[8i:8i+7].
  - Key byte j goes to shadow_key[8j:8j+7].
  - Frame length is 32/40/48 bytes.
- States:
  - IDLE: waits for the first byte. On that byte, latch the mode (3 maps to 0), clear shadow_key to 0, store the byte, go to TEXT, and set byte_cnt=1.
  - TEXT: stores bytes. When the byte with byte_cnt=15 is accepted, go to KEY.
  - KEY: stores bytes. When the last key byte is accepted (byte_cnt = 15+KB), perform the commit described below and go to DONE.
  - DONE: one cycle. Returns to IDLE.
- Commit on the same edge that accepts the last key byte:
  - text_out <= shadow_text with the final byte merged.
  - key_out <= shadow_key with the final byte merged.
  - key_mode <= latched mode.
  - load <= 1.
- Outputs are otherwise held; partial frames never reach text_out/key_out.
- byte_ready = (state != DONE); combinational from state.
- busy = (state == TEXT or KEY).
- abort:
  - In TEXT/KEY: the next edge goes to IDLE and discards the shadow; no load, no frame_err.
  - When coincident with a transfer, abort wins and the byte is dropped.
  - In IDLE or DONE: ignored (a commit already made stands).
- Timeout:
  - idle_cnt counts edges in TEXT/KEY with no transfer; it is cleared on every transfer and on entry to IDLE.
  - When idle_cnt reaches TIMEOUT (TIMEOUT>0): frame_err <= 1 for one cycle, state goes to IDLE, and the shadow is discarded.
  - A transfer on the same edge as expiry is accepted and the timeout does not fire.
  - Abort on the same edge suppresses frame_err.
- Counter widths: byte_cnt is 6 bits (max 47); idle_cnt is $clog2(TIMEOUT+1) bits and saturates.

## Timing
- Reset values:
  - state=IDLE, byte_cnt=0, idle_cnt=0.
  - load=0, frame_err=0, busy=0, byte_ready=1.
  - text_out=128'h00112233445566778899aabbccddeeff.
  - key_out=256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f.
  - key_mode=0.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is lost.
- Throughput: one byte per cycle. A 32-byte frame accepted on consecutive edges e1..e32 gives load high in the cycle after e32 and byte_ready low in that same cycle. The next frame's first byte can be accepted at e34.
- Latency: last accepted byte to load = 1 edge. text_out/key_out change on the same edge load rises; load, frame_err and busy are registered outputs.
- Sustained back-to-back frames: one dead cycle (DONE) per frame.

## Test plan
- Mode 0, 32 consecutive bytes: text 00..ff-pattern 0x00,0x11..0xff, key 0x00..0x0f.
  - load pulses once, 1 cycle after the last byte.
  - text_out=00112233…eeff; key_out=000102…0f followed by 128 zero bits; key_mode=0.
- Mode 2, 48 bytes with byte_valid deasserted 3 cycles between every byte (TIMEOUT=1000): key_out=000102…1f, key_mode=2, load once; outputs unchanged before load.
- Mode 1, frame stalled after byte 20 for TIMEOUT=8 cycles: frame_err pulses on the 8th idle edge, busy falls, no load, outputs still hold their prior values. A following full mode-1 frame (40 bytes) loads correctly.
- abort asserted together with byte 10 in mode 0: byte dropped, IDLE next cycle, no load/frame_err. A new frame sampled with mode=3 loads as a 128-bit key.
- rst_n pulsed low at byte 25 of a mode-2 frame: outputs return to the reset constants asynchronously, byte_ready=1, busy=0; the subsequent complete frame loads.
- Two mode-0 frames back to back with byte_valid held high: byte_ready low exactly one cycle between frames, two load pulses 33 cycles apart, second frame's data on outputs.

Source files
------------

// File: rtl/aes_frame_loader_if.sv
// Byte-stream handshake plus the committed text/key bundle handed to the AES chain.
interface aes_frame_loader_if;
  logic [7:0]   byte_in;
  logic         byte_valid;
  logic         byte_ready;
  logic [1:0]   mode;
  logic         abort;
  logic [0:127] text_out;
  logic [0:255] key_out;
  logic [1:0]   key_mode;
  logic         load;
  logic         busy;
  logic         frame_err;

  // Byte producer side
  modport master (
    output byte_in, byte_valid, mode, abort,
    input  byte_ready, text_out, key_out, key_mode, load, busy, frame_err
  );

  // Loader side
  modport slave (
    input  byte_in, byte_valid, mode, abort,
    output byte_ready, text_out, key_out, key_mode, load, busy, frame_err
  );
endinterface

// File: rtl/aes_frame_loader.sv
// Byte-serial loader: assembles a 128-bit text and a 128/192/256-bit key in
// shadow registers and commits them atomically with a one-cycle load pulse.
module aes_frame_loader #(
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  aes_frame_loader_if.slave bus
);

  localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [0:127] TEXT_RST = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:255] KEY_RST  =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  typedef enum logic [1:0] {IDLE, TEXT, KEY, DONE} state_t;

  state_t         state, state_nxt;
  logic [5:0]     byte_cnt;
  logic [IW-1:0]  idle_cnt;
  logic [1:0]     mode_q;
  logic [0:127]   shadow_text;
  logic [0:255]   shadow_key;
  logic [0:255]   key_merged;
  logic [5:0]     last_cnt;
  logic [4:0]     kidx;
  logic           xfer, in_frame, abort_hit, expire;

  assign bus.byte_ready = (state != DONE);
  assign xfer      = bus.byte_valid && bus.byte_ready;
  assign in_frame  = (state == TEXT) || (state == KEY);
  assign abort_hit = in_frame && bus.abort;
  // Expiry fires on the idle edge that would bring idle_cnt up to TIMEOUT;
  // a transfer on that same edge keeps the frame alive.
  assign expire    = (TIMEOUT > 0) && in_frame && !xfer &&
                     (idle_cnt == IW'(TIMEOUT - 1));
  // Key byte j lives at byte_cnt = 16 + j.
  assign kidx      = 5'(byte_cnt - 6'd16);

  // Final byte count of the frame for the latched key size.
  always_comb begin
    last_cnt = 6'd31;
    case (mode_q)
      2'd1:    last_cnt = 6'd39;
      2'd2:    last_cnt = 6'd47;
      default: last_cnt = 6'd31;
    endcase
  end

  // Key shadow with the incoming byte merged, used on the commit edge.
  always_comb begin
    key_merged = shadow_key;
    key_merged[{kidx, 3'b000} +: 8] = bus.byte_in;
  end

  // Next-state logic; abort outranks both timeout and transfer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (xfer) state_nxt = TEXT;
      TEXT: begin
        if (abort_hit || expire)             state_nxt = IDLE;
        else if (xfer && byte_cnt == 6'd15)  state_nxt = KEY;
      end
      KEY: begin
        if (abort_hit || expire)             state_nxt = IDLE;
        else if (xfer && byte_cnt == last_cnt) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Shadow capture, counters, commit and status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt      <= '0;
      idle_cnt      <= '0;
      mode_q        <= '0;
      shadow_text   <= '0;
      shadow_key    <= '0;
      bus.text_out  <= TEXT_RST;
      bus.key_out   <= KEY_RST;
      bus.key_mode  <= '0;
      bus.load      <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.load      <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.busy      <= (state_nxt == TEXT) || (state_nxt == KEY);
      case (state)
        IDLE: begin
          idle_cnt <= '0;
          if (xfer) begin
            mode_q                 <= (bus.mode == 2'd3) ? 2'd0 : bus.mode;
            shadow_key             <= '0;
            shadow_text[0 +: 8]    <= bus.byte_in;
            byte_cnt               <= 6'd1;
          end
        end
        TEXT, KEY: begin
          if (abort_hit) begin
            byte_cnt <= '0;
            idle_cnt <= '0;
          end else if (xfer) begin
            idle_cnt <= '0;
            byte_cnt <= byte_cnt + 6'd1;
            if (state == TEXT) begin
              shadow_text[{byte_cnt[3:0], 3'b000} +: 8] <= bus.byte_in;
            end else begin
              shadow_key <= key_merged;
              if (byte_cnt == last_cnt) begin
                bus.text_out <= shadow_text;
                bus.key_out  <= key_merged;
                bus.key_mode <= mode_q;
                bus.load     <= 1'b1;
                byte_cnt     <= '0;
              end
            end
          end else if (expire) begin
            bus.frame_err <= 1'b1;
            byte_cnt      <= '0;
            idle_cnt      <= '0;
          end else if (idle_cnt != {IW{1'b1}}) begin
            idle_cnt <= idle_cnt + IW'(1);
          end
        end
        DONE: idle_cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_frame_loader.sv
// Directed frames with hand-computed results; a monitor matches every load /
// frame_err pulse against a queue of expected events.
module tb_aes_frame_loader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes_frame_loader_if bus();
  aes_frame_loader #(.TIMEOUT(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    bit           err;
    logic [127:0] text;
    logic [255:0] key;
    logic [1:0]   km;
  } exp_t;

  exp_t sb[$];
  int   load_cyc[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   stalls;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_load(input logic [127:0] t, input logic [255:0] k, input logic [1:0] m);
    exp_t e;
    e.err = 1'b0; e.text = t; e.key = k; e.km = m;
    sb.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.err = 1'b1; e.text = '0; e.key = '0; e.km = '0;
    sb.push_back(e);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && (bus.load || bus.frame_err)) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_event load=%b frame_err=%b required=none", bus.load, bus.frame_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.err) begin
          chk("frame_err_evt", {254'd0, bus.frame_err, bus.load}, 256'd2);
        end else begin
          chk("load_evt", {254'd0, bus.load, bus.frame_err}, 256'd2);
          chk("text_out", bus.text_out, e.text);
          chk("key_out", bus.key_out, e.key);
          chk("key_mode", bus.key_mode, e.km);
          load_cyc.push_back(cyc);
        end
      end
    end
  end

  function automatic logic [7:0] fbyte(input int i, input logic [7:0] t0,
                                       input logic [7:0] ts, input logic [7:0] k0);
    logic [7:0] ii;
    ii = 8'(i);
    if (i < 16) return 8'(t0 + ts * ii);
    return 8'(k0 + ii - 8'd16);
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] b);
    int n;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    n = 0;
    while (!bus.byte_ready && n < 10) begin
      stalls++;
      @(negedge clk);
      n++;
    end
    if (n >= 10) begin
      tests++; fails++;
      $display("FAIL byte_ready_wait actual=timeout required=ready");
    end
    @(negedge clk);
  endtask

  task automatic send_range(input int from, input int to, input logic [7:0] t0,
                            input logic [7:0] ts, input logic [7:0] k0, input int gap);
    for (int i = from; i < to; i++) begin
      send(fbyte(i, t0, ts, k0));
      if (gap > 0) begin
        bus.byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
  endtask

  localparam logic [127:0] T1_TEXT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] T1_KEY  = 256'h000102030405060708090a0b0c0d0e0f00000000000000000000000000000000;
  localparam logic [127:0] T2_TEXT = 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0;
  localparam logic [255:0] T2_KEY  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] RST_TEXT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] RST_KEY  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.byte_in = '0; bus.byte_valid = 1'b0; bus.mode = '0; bus.abort = 1'b0;
    stalls = 0;
    repeat (2) @(negedge clk);
    chk("rst_text", bus.text_out, RST_TEXT);
    chk("rst_key", bus.key_out, RST_KEY);
    chk("rst_flags", {250'd0, bus.key_mode, bus.load, bus.frame_err, bus.busy, bus.byte_ready}, 256'h1);
    rst_n = 1'b1;
    @(negedge clk);

    // Mode 0, 32 consecutive bytes.
    bus.mode = 2'd0;
    push_load(T1_TEXT, T1_KEY, 2'd0);
    send_range(0, 32, 8'h00, 8'h11, 8'h00, 0);
    bus.byte_valid = 1'b0;
    chk("t1_ready_low_in_done", bus.byte_ready, 1'b0);
    repeat (2) @(negedge clk);

    // Mode 2 with 3-cycle gaps; mode changed mid-frame must be ignored.
    bus.mode = 2'd2;
    push_load(T2_TEXT, T2_KEY, 2'd2);
    send_range(0, 1, 8'hff, 8'hff, 8'h00, 3);
    bus.mode = 2'd0;
    send_range(1, 47, 8'hff, 8'hff, 8'h00, 3);
    chk("t2_text_hold", bus.text_out, T1_TEXT);
    chk("t2_key_hold", bus.key_out, T1_KEY);
    chk("t2_busy", bus.busy, 1'b1);
    send_range(47, 48, 8'hff, 8'hff, 8'h00, 0);
    bus.byte_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Mode 1 stalled after 20 bytes: timeout after 8 idle edges.
    bus.mode = 2'd1;
    send_range(0, 20, 8'h10, 8'h01, 8'ha0, 0);
    bus.byte_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("t3_no_err_at_7", bus.frame_err, 1'b0);
    chk("t3_busy_at_7", bus.busy, 1'b1);
    push_err();
    @(negedge clk);
    chk("t3_err_at_8", bus.frame_err, 1'b1);
    chk("t3_busy_fell", bus.busy, 1'b0);
    @(negedge clk);
    chk("t3_err_one_cycle", bus.frame_err, 1'b0);
    chk("t3_text_hold", bus.text_out, T2_TEXT);
    chk("t3_key_hold", bus.key_out, T2_KEY);

    // Full mode-1 frame; a transfer on the would-be expiry edge keeps it alive.
    push_load(128'h101112131415161718191a1b1c1d1e1f,
              256'ha0a1a2a3a4a5a6a7a8a9aaabacadaeafb0b1b2b3b4b5b6b70000000000000000, 2'd1);
    send_range(0, 6, 8'h10, 8'h01, 8'ha0, 0);
    bus.byte_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("t3b_busy_after_gap", bus.busy, 1'b1);
    send_range(6, 40, 8'h10, 8'h01, 8'ha0, 0);
    bus.byte_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Abort coincident with byte 10, then a mode-3 frame loads as 128-bit key.
    bus.mode = 2'd0;
    send_range(0, 9, 8'hc0, 8'h01, 8'hd0, 0);
    bus.abort = 1'b1;
    send(8'hc9);
    bus.abort = 1'b0;
    bus.byte_valid = 1'b0;
    chk("t4_busy_after_abort", bus.busy, 1'b0);
    chk("t4_ready_after_abort", bus.byte_ready, 1'b1);
    repeat (3) @(negedge clk);
    bus.mode = 2'd3;
    push_load(128'h202122232425262728292a2b2c2d2e2f,
              256'h303132333435363738393a3b3c3d3e3f00000000000000000000000000000000, 2'd0);
    send_range(0, 32, 8'h20, 8'h01, 8'h30, 0);
    bus.byte_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset pulsed during byte 25 of a mode-2 frame.
    bus.mode = 2'd2;
    send_range(0, 24, 8'he0, 8'h01, 8'hf0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_text", bus.text_out, RST_TEXT);
    chk("t5_rst_key", bus.key_out, RST_KEY);
    chk("t5_rst_flags", {251'd0, bus.key_mode, bus.load, bus.busy, bus.byte_ready}, 256'h1);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    push_load(128'h404142434445464748494a4b4c4d4e4f,
              256'h505152535455565758595a5b5c5d5e5f606162636465666768696a6b6c6d6e6f, 2'd2);
    send_range(0, 48, 8'h40, 8'h01, 8'h50, 0);
    bus.byte_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Two mode-0 frames back to back with byte_valid held high.
    bus.mode = 2'd0;
    push_load(128'h606162636465666768696a6b6c6d6e6f,
              256'h707172737475767778797a7b7c7d7e7f00000000000000000000000000000000, 2'd0);
    push_load(128'h808182838485868788898a8b8c8d8e8f,
              256'h909192939495969798999a9b9c9d9e9f00000000000000000000000000000000, 2'd0);
    send_range(0, 32, 8'h60, 8'h01, 8'h70, 0);
    stalls = 0;
    send_range(0, 32, 8'h80, 8'h01, 8'h90, 0);
    bus.byte_valid = 1'b0;
    chk("t6_ready_low_cycles", stalls, 1);
    repeat (3) @(negedge clk);
    if (load_cyc.size() >= 2)
      chk("t6_load_spacing", load_cyc[load_cyc.size()-1] - load_cyc[load_cyc.size()-2], 33);
    chk("t6_text_final", bus.text_out, 128'h808182838485868788898a8b8c8d8e8f);

    chk("sb_drained", sb.size(), 0);
    chk("load_count", load_cyc.size(), 7);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
